// File: rtl/dvp_frame_packer.sv
// rtl/dvp_frame_packer.sv - DVP byte stream packer into 128-bit FIFO words, one frame per enable
// Skips SKIP_FRAMES frames, captures one, pads the tail word, then holds done until iEn falls.
module dvp_frame_packer #(
  parameter int SKIP_FRAMES = 2,
  parameter int MAX_WORDS   = 1048576
) (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iEn,
  input  logic         iVSYNC,
  input  logic         iHREF,
  input  logic [7:0]   iData,
  output logic         oWrEn_FIFO,
  output logic [127:0] oWrData_FIFO,
  input  logic         iFull_FIFO,
  output logic         oWrFrm2FIFODone,
  output logic [31:0]  oWrFrmBytes,
  output logic         oOverflow
);

  localparam int WCW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, SKIP, WAIT_SOF, CAPTURE, FLUSH, DONE_WAIT, DONE
  } state_e;

  state_e         state_q;
  logic           vs_q;
  logic           pend_q;
  logic           dw_q;
  logic [31:0]    skip_q;
  logic [3:0]     lane_q;
  logic [WCW-1:0] wcnt_q;
  logic [127:0]   asm_q;
  logic [127:0]   data_q;
  logic [31:0]    bytes_q;
  logic           ovf_q;
  logic [127:0]   word_d;
  logic           sof;
  logic           eof;
  logic           wr_issue;

  assign sof = vs_q & ~iVSYNC;
  assign eof = ~vs_q & iVSYNC;

  // FIFO full is only known in the write cycle itself, so the strobe is gated combinationally.
  assign wr_issue = pend_q & ~iFull_FIFO & (wcnt_q < WCW'(MAX_WORDS));

  assign oWrEn_FIFO      = wr_issue;
  assign oWrData_FIFO    = data_q;
  assign oWrFrm2FIFODone = (state_q == DONE);
  assign oWrFrmBytes     = bytes_q;
  assign oOverflow       = ovf_q;

  always_comb begin
    word_d = asm_q;
    word_d[{~lane_q, 3'b000} +: 8] = iData;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      vs_q    <= 1'b1;
      pend_q  <= 1'b0;
      dw_q    <= 1'b0;
      skip_q  <= '0;
      lane_q  <= '0;
      wcnt_q  <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      bytes_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vs_q <= iVSYNC;
      if (pend_q) begin
        pend_q <= 1'b0;
        if (wr_issue) begin
          bytes_q <= bytes_q + 32'd16;
          wcnt_q  <= wcnt_q + WCW'(1);
        end else begin
          ovf_q <= 1'b1;
        end
      end
      if (!iEn) begin
        state_q <= IDLE;
        pend_q  <= 1'b0;
        dw_q    <= 1'b0;
        skip_q  <= '0;
        lane_q  <= '0;
        wcnt_q  <= '0;
        asm_q   <= '0;
        bytes_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            skip_q  <= '0;
            state_q <= (SKIP_FRAMES == 0) ? WAIT_SOF : SKIP;
          end
          SKIP: begin
            if (eof) begin
              if (skip_q + 32'd1 == 32'(SKIP_FRAMES)) state_q <= WAIT_SOF;
              else skip_q <= skip_q + 32'd1;
            end
          end
          WAIT_SOF: begin
            if (sof) begin
              state_q <= CAPTURE;
              lane_q  <= '0;
              wcnt_q  <= '0;
              bytes_q <= '0;
              asm_q   <= '0;
            end
          end
          CAPTURE: begin
            if (iHREF) begin
              lane_q <= lane_q + 4'd1;
              if (lane_q == 4'd15) begin
                data_q <= word_d;
                asm_q  <= '0;
                pend_q <= 1'b1;
              end else begin
                asm_q <= word_d;
              end
            end
            if (eof) state_q <= FLUSH;
          end
          FLUSH: begin
            // A word pending from the EOF cycle is issued here while lane is already 0.
            if (lane_q != 4'd0) begin
              data_q <= asm_q;
              asm_q  <= '0;
              pend_q <= 1'b1;
              lane_q <= '0;
            end else begin
              state_q <= DONE_WAIT;
              dw_q    <= 1'b0;
            end
          end
          DONE_WAIT: begin
            if (dw_q) state_q <= DONE;
            else dw_q <= 1'b1;
          end
          DONE: state_q <= DONE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dvp_frame_packer.sv
// tb/tb_dvp_frame_packer.sv - directed frames against a frame-level byte/word model of dvp_frame_packer
module tb_dvp_frame_packer;

  localparam int SKIP = 2;
  localparam int MAXW = 8;

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic         en   = 1'b0;
  logic         vs   = 1'b1;
  logic         href = 1'b0;
  logic         full = 1'b0;
  logic [7:0]   dat  = 8'd0;
  logic         wen;
  logic [127:0] wdata;
  logic         done;
  logic [31:0]  nbytes;
  logic         ovf;

  dvp_frame_packer #(.SKIP_FRAMES(SKIP), .MAX_WORDS(MAXW)) dut (
    .iClk(clk), .iRstN(rstn), .iEn(en), .iVSYNC(vs), .iHREF(href), .iData(dat),
    .oWrEn_FIFO(wen), .oWrData_FIFO(wdata), .iFull_FIFO(full),
    .oWrFrm2FIFODone(done), .oWrFrmBytes(nbytes), .oOverflow(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic [127:0] d; } wr_t;

  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           phase, eofs, done_cyc, m_words, base;
  logic         pvs;
  logic         m_ovf;
  logic [31:0]  m_bytes;
  logic [7:0]   q[$];
  wr_t          wq[$];
  logic [127:0] got[$];
  logic [7:0]   fb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] pack();
    logic [127:0] w;
    w = '0;
    foreach (q[i]) w[127 - 8*i -: 8] = q[i];
    return w;
  endfunction

  function automatic logic [127:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 128'd0;
  endfunction

  task automatic model_clear();
    phase = 0; eofs = 0; done_cyc = 0; m_words = 0; m_bytes = '0;
    q.delete(); wq.delete();
  endtask

  // Per-cycle comparison against the model, then the model absorbs this cycle's inputs.
  task automatic cycle_check();
    logic         exp_wen, drop, eof_s, sof_s;
    logic [127:0] exp_d;
    cyc++;
    if (!rstn) begin
      chk("rst_wen", 128'(wen), 128'd0);
      chk("rst_data", wdata, 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_bytes", 128'(nbytes), 128'd0);
      chk("rst_ovf", 128'(ovf), 128'd0);
      model_clear(); m_ovf = 1'b0; pvs = 1'b1;
      return;
    end
    exp_wen = 1'b0; drop = 1'b0; exp_d = '0;
    if (wq.size() > 0 && wq[0].c == cyc) begin
      if (!full && m_words < MAXW) begin exp_wen = 1'b1; exp_d = wq[0].d; end
      else drop = 1'b1;
      void'(wq.pop_front());
    end
    chk("wr_en", 128'(wen), 128'(exp_wen));
    if (exp_wen) chk("wr_data", wdata, exp_d);
    if (wen) got.push_back(wdata);
    chk("frm_bytes", 128'(nbytes), 128'(m_bytes));
    chk("done", 128'(done), 128'(phase == 4 && cyc >= done_cyc));
    chk("overflow", 128'(ovf), 128'(m_ovf));
    if (exp_wen) begin m_bytes = m_bytes + 32'd16; m_words++; end
    if (drop) m_ovf = 1'b1;
    eof_s = !pvs && vs;
    sof_s = pvs && !vs;
    if (!en) model_clear();
    else begin
      case (phase)
        0: begin phase = (SKIP == 0) ? 2 : 1; eofs = 0; end
        1: if (eof_s) begin eofs++; if (eofs == SKIP) phase = 2; end
        2: if (sof_s) begin phase = 3; q.delete(); m_bytes = '0; m_words = 0; end
        3: begin
          if (href) begin
            q.push_back(dat);
            if (q.size() == 16) begin wq.push_back('{cyc + 1, pack()}); q.delete(); end
          end
          if (eof_s) begin
            phase = 4;
            if (q.size() > 0) begin
              wq.push_back('{cyc + 2, pack()}); q.delete(); done_cyc = cyc + 5;
            end else done_cyc = cyc + 4;
          end
        end
        default: ;
      endcase
    end
    pvs = vs;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #2;
  endtask

  task automatic load_ramp(input int start, input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'(start + i));
  endtask

  task automatic frame(input int nb, input int line_len, input int full_idx);
    vs = 1'b0; tick(); tick();
    for (int b = 0; b < nb; b += line_len) begin
      for (int i = 0; i < line_len && b + i < nb; i++) begin
        href = 1'b1; dat = fb[b + i]; full = (b + i == full_idx); tick();
      end
      href = 1'b0; full = 1'b0; tick(); tick();
    end
    vs = 1'b1; tick(); tick(); tick();
  endtask

  initial begin
    model_clear(); m_ovf = 1'b0; pvs = 1'b1;
    tick(); tick();
    chk("init_wen", 128'(wen), 128'd0);
    chk("init_bytes", 128'(nbytes), 128'd0);
    chk("init_done", 128'(done), 128'd0);
    rstn = 1'b1; tick();

    // Three ramp frames, only the third captured.
    load_ramp(0, 128); base = got.size();
    en = 1'b1; tick();
    repeat (3) frame(128, 32, -1);
    repeat (4) tick();
    chk("t1_writes", 128'(got.size() - base), 128'd8);
    chk("t1_first", got_at(base), 128'h000102030405060708090a0b0c0d0e0f);
    chk("t1_last", got_at(base + 7), 128'h707172737475767778797a7b7c7d7e7f);
    chk("t1_bytes", 128'(nbytes), 128'd128);
    chk("t1_done", 128'(done), 128'd1);
    chk("t1_ovf", 128'(ovf), 128'd0);
    en = 1'b0; tick(); tick();
    chk("t1_done_clr", 128'(done), 128'd0);

    // 20-byte frame: tail word padded with zeros.
    load_ramp(8'hA0, 20); base = got.size();
    en = 1'b1; tick();
    frame(0, 1, -1); frame(0, 1, -1); frame(20, 32, -1);
    repeat (4) tick();
    chk("t2_writes", 128'(got.size() - base), 128'd2);
    chk("t2_pad", got_at(base + 1), 128'hb0b1b2b3_00000000_00000000_00000000);
    chk("t2_bytes", 128'(nbytes), 128'd32);
    en = 1'b0; tick(); tick();

    // Sixteenth byte coincides with EOF.
    load_ramp(8'h10, 16); base = got.size();
    en = 1'b1; tick();
    frame(0, 1, -1); frame(0, 1, -1);
    vs = 1'b0; tick(); tick();
    for (int i = 0; i < 15; i++) begin href = 1'b1; dat = fb[i]; tick(); end
    vs = 1'b1; dat = fb[15]; tick();
    href = 1'b0; repeat (8) tick();
    chk("t3_writes", 128'(got.size() - base), 128'd1);
    chk("t3_word", got_at(base), 128'h101112131415161718191a1b1c1d1e1f);
    chk("t3_bytes", 128'(nbytes), 128'd16);
    chk("t3_done", 128'(done), 128'd1);
    en = 1'b0; tick(); tick();

    // Nine words offered with an 8-word cap.
    load_ramp(0, 144); base = got.size();
    en = 1'b1; tick();
    frame(0, 1, -1); frame(0, 1, -1); frame(144, 48, -1);
    repeat (4) tick();
    chk("cap_writes", 128'(got.size() - base), 128'd8);
    chk("cap_bytes", 128'(nbytes), 128'd128);
    chk("cap_ovf", 128'(ovf), 128'd1);
    en = 1'b0; tick(); tick();

    // iEn drop mid-capture, skip restart, then async reset mid-frame.
    base = got.size();
    en = 1'b1; tick();
    frame(0, 1, -1); frame(0, 1, -1);
    vs = 1'b0; tick(); tick();
    for (int i = 0; i < 10; i++) begin href = 1'b1; dat = fb[i]; tick(); end
    href = 1'b0; en = 1'b0; tick(); tick();
    chk("t5_writes", 128'(got.size() - base), 128'd0);
    chk("t5_done", 128'(done), 128'd0);
    chk("t5_bytes", 128'(nbytes), 128'd0);
    en = 1'b1; tick();
    frame(16, 16, -1); frame(16, 16, -1);
    chk("t5_reskip", 128'(got.size() - base), 128'd0);
    vs = 1'b0; tick(); tick();
    for (int i = 0; i < 20; i++) begin href = 1'b1; dat = fb[i]; tick(); end
    chk("t5_prerst", 128'(got.size() - base), 128'd1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_wen", 128'(wen), 128'd0);
    chk("arst_data", wdata, 128'd0);
    chk("arst_bytes", 128'(nbytes), 128'd0);
    chk("arst_ovf", 128'(ovf), 128'd0);
    href = 1'b0; tick();
    rstn = 1'b1; tick();
    vs = 1'b1; tick(); tick(); tick();

    // 64-byte frame with FIFO full during the third word's write cycle.
    frame(0, 1, -1);
    base = got.size();
    frame(64, 32, 48);
    repeat (4) tick();
    chk("t6_writes", 128'(got.size() - base), 128'd3);
    chk("t6_ovf", 128'(ovf), 128'd1);
    chk("t6_bytes", 128'(nbytes), 128'd48);
    en = 1'b0; tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
